// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings and the combinational datapath for alu_exec_unit.
// Holds the op-type codes, funct3 values, FSM state encoding and result function.
package alu_exec_unit_pkg;

  localparam int ROB_BITS_DFLT = 4;

  localparam logic [1:0] ALU_TYPE_U = 2'd0;
  localparam logic [1:0] ALU_TYPE_I = 2'd1;
  localparam logic [1:0] ALU_TYPE_B = 2'd2;
  localparam logic [1:0] ALU_TYPE_R = 2'd3;
  localparam logic [5:0] ALU_OP_J   = 6'b111111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic [31:0] alu_operand2(input logic [5:0] op,
                                                input logic [31:0] vk,
                                                input logic [31:0] imm);
    return (op[1:0] == ALU_TYPE_I) ? imm : vk;
  endfunction

  // J shares type bits with R, so it is excluded before looking at funct3.
  function automatic logic op_is_shift(input logic [5:0] op);
    return (op != ALU_OP_J) &&
           ((op[1:0] == ALU_TYPE_I) || (op[1:0] == ALU_TYPE_R)) &&
           ((op[4:2] == F3_SLL) || (op[4:2] == F3_SR));
  endfunction

  function automatic logic [31:0] alu_result(input logic [5:0] op,
                                              input logic [31:0] vj,
                                              input logic [31:0] vk,
                                              input logic [31:0] imm);
    logic [31:0] b;
    logic [4:0]  sh;
    logic        taken;
    logic [31:0] res;
    b     = alu_operand2(op, vk, imm);
    sh    = b[4:0];
    taken = 1'b0;
    res   = '0;
    if ((op == ALU_OP_J) || (op[1:0] == ALU_TYPE_U)) begin
      res = imm;
    end else if (op[1:0] == ALU_TYPE_B) begin
      case (op[4:2])
        F3_BEQ:  taken = (vj == b);
        F3_BNE:  taken = (vj != b);
        F3_BLT:  taken = ($signed(vj) < $signed(b));
        F3_BGE:  taken = ($signed(vj) >= $signed(b));
        F3_BLTU: taken = (vj < b);
        F3_BGEU: taken = (vj >= b);
        default: taken = 1'b0;
      endcase
      res = {31'b0, taken};
    end else begin
      case (op[4:2])
        F3_ADD:  res = ((op[1:0] == ALU_TYPE_R) && op[5]) ? vj - b : vj + b;
        F3_SLL:  res = vj << sh;
        F3_SLT:  res = {31'b0, ($signed(vj) < $signed(b))};
        F3_SLTU: res = {31'b0, (vj < b)};
        F3_XOR:  res = vj ^ b;
        F3_SR:   res = op[5] ? $unsigned($signed(vj) >>> sh) : vj >> sh;
        F3_OR:   res = vj | b;
        default: res = vj & b;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the reservation station (master) and the ALU (slave).
interface alu_exec_unit_if
  import alu_exec_unit_pkg::*;
#(
  parameter int RoB_BITS = ROB_BITS_DFLT
);
  logic                start;
  logic [31:0]         vj;
  logic [31:0]         vk;
  logic [31:0]         imm;
  logic [5:0]          op;
  logic [RoB_BITS-1:0] rob_id;
  logic                busy;
  logic                out_rdy;
  logic [RoB_BITS-1:0] out_id;
  logic [31:0]         out_value;

  modport master (output start, vj, vk, imm, op, rob_id,
                  input  busy, out_rdy, out_id, out_value);
  modport slave  (input  start, vj, vk, imm, op, rob_id,
                  output busy, out_rdy, out_id, out_value);
endinterface

// File: rtl/alu_exec_unit_shifter.sv
// Bit-serial shifter, one position per enabled cycle; built only with ALU_SERIAL_SHIFT_EN.
// done flags the cycle whose step produces the final value on result.
`ifdef ALU_SERIAL_SHIFT_EN
module alu_serial_shifter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [4:0]  amount,
  input  logic        dir,
  input  logic        arith,
  output logic        done,
  output logic [31:0] result
);
  logic [31:0] shift_q;
  logic [4:0]  cnt_q;
  logic        dir_q;
  logic        arith_q;
  logic [31:0] step;

  assign step   = dir_q ? {arith_q & shift_q[31], shift_q[31:1]} : {shift_q[30:0], 1'b0};
  assign done   = (cnt_q == 5'd1);
  assign result = step;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shift_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      shift_q <= value;
      cnt_q   <= amount;
      dir_q   <= dir;
      arith_q <= arith;
    end else if (en && (cnt_q != 5'd0)) begin
      shift_q <= step;
      cnt_q   <= cnt_q - 5'd1;
    end
  end
endmodule
`endif

// File: rtl/alu_exec_unit.sv
// Single-issue integer execute unit; ALU_SERIAL_SHIFT_EN selects bit-serial shifts
// instead of the single-cycle barrel shifter.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_SHIFT | serial shift in progress (ALU_SERIAL_SHIFT_EN only)
//   ST_DONE  | result broadcast on out_rdy for one rdy cycle
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int RoB_BITS = ROB_BITS_DFLT
) (
  input logic            clk_in,
  input logic            rst_in,
  input logic            rdy_in,
  input logic            clear,
  alu_exec_unit_if.slave bus
);
  alu_state_e          state_q, state_d;
  logic [RoB_BITS-1:0] out_id_q;
  logic [31:0]         out_value_q;
  logic                accept;
  logic                serial_go;
  logic                sh_done;

  assign accept = (state_q == ST_IDLE) && bus.start;

`ifdef ALU_SERIAL_SHIFT_EN
  logic [31:0] opnd2;
  logic [31:0] sh_result;
  logic        sh_load;

  assign opnd2     = alu_operand2(bus.op, bus.vk, bus.imm);
  // shamt 0 is a plain copy of vj and takes the single-cycle path.
  assign serial_go = op_is_shift(bus.op) && (opnd2[4:0] != 5'd0);
  assign sh_load   = accept && serial_go && rdy_in && !clear;

  alu_serial_shifter u_shifter (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .en     (rdy_in && !clear),
    .load   (sh_load),
    .value  (bus.vj),
    .amount (opnd2[4:0]),
    .dir    (bus.op[4:2] == F3_SR),
    .arith  ((bus.op[4:2] == F3_SR) && bus.op[5]),
    .done   (sh_done),
    .result (sh_result)
  );
`else
  assign serial_go = 1'b0;
  assign sh_done   = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (rdy_in) begin
      unique case (state_q)
        ST_IDLE:  if (bus.start) state_d = serial_go ? ST_SHIFT : ST_DONE;
        ST_SHIFT: if (sh_done)   state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // clear masks the flags combinationally so a squashed result is never seen.
  always_comb begin
    bus.busy    = (state_q != ST_IDLE) && !clear;
    bus.out_rdy = (state_q == ST_DONE) && !clear;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      out_id_q    <= '0;
      out_value_q <= '0;
    end else if (!clear && rdy_in) begin
      if (accept) begin
        out_id_q <= bus.rob_id;
        if (!serial_go) out_value_q <= alu_result(bus.op, bus.vj, bus.vk, bus.imm);
      end
`ifdef ALU_SERIAL_SHIFT_EN
      if ((state_q == ST_SHIFT) && sh_done) out_value_q <= sh_result;
`endif
    end
  end

  assign bus.out_id    = out_id_q;
  assign bus.out_value = out_value_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !clear)
      assert (!(bus.start && bus.busy)) else $error("alu_exec_unit: start ignored while busy");
  end
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit; expected latencies follow ALU_SERIAL_SHIFT_EN.
module tb_alu_exec_unit;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] imm;
    logic [31:0] exp;
    logic [4:0]  k;
  } vec_t;

  vec_t vecs [18];

  alu_exec_unit_if #(.RoB_BITS(4)) bus ();

  alu_exec_unit #(.RoB_BITS(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [31:0] imm, input logic [3:0] id);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.vj     = vj;
    bus.vk     = vk;
    bus.imm    = imm;
    bus.rob_id = id;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    clear  = 1'b0;
    drive(6'b000011, 32'd1, 32'd2, 32'd3, 4'hF);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_in);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      total++; if (bus.out_rdy !== 1'b0) begin bad++; $display("FAIL reset_out_rdy: got %b want 0", bus.out_rdy); end
      total++; if (bus.out_id !== 4'h0) begin bad++; $display("FAIL reset_out_id: got %h want 0", bus.out_id); end
      total++; if (bus.out_value !== 32'h0) begin bad++; $display("FAIL reset_out_value: got %h want 0", bus.out_value); end
    end
    step();
    rst_in    = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic test_alu_ops();
    int         lat;
    logic [3:0] id;
    vecs = '{
      '{6'b100011, 32'd5,        32'd7,        32'd0,        32'hFFFFFFFE, 5'd0},
      '{6'b010010, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd1,        5'd0},
      '{6'b011010, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        5'd0},
      '{6'b110101, 32'h80000000, 32'd0,        32'd4,        32'hF8000000, 5'd4},
      '{6'b100001, 32'd1,        32'd0,        32'hFFFFFFFF, 32'd0,        5'd0},
      '{6'b001011, 32'hFFFFFFFE, 32'd1,        32'd0,        32'd1,        5'd0},
      '{6'b001111, 32'hFFFFFFFE, 32'd1,        32'd0,        32'd0,        5'd0},
      '{6'b010001, 32'hF0F0F0F0, 32'd0,        32'h0FF00FF0, 32'hFF00FF00, 5'd0},
      '{6'b000000, 32'd0,        32'd0,        32'h12345000, 32'h12345000, 5'd0},
      '{6'b111111, 32'd0,        32'd0,        32'h00000100, 32'h00000100, 5'd0},
      '{6'b000110, 32'd3,        32'd3,        32'd0,        32'd0,        5'd0},
      '{6'b001010, 32'd1,        32'd2,        32'd0,        32'd0,        5'd0},
      '{6'b000111, 32'd1,        32'h21,       32'd0,        32'd2,        5'd1},
      '{6'b010101, 32'h80000000, 32'd0,        32'h1F,       32'd1,        5'd31},
      '{6'b110111, 32'h80000000, 32'h20,       32'd0,        32'h80000000, 5'd0},
      '{6'b011111, 32'hFF00FF00, 32'h0F0F0F0F, 32'd0,        32'h0F000F00, 5'd0},
      '{6'b011110, 32'd2,        32'd2,        32'd0,        32'd1,        5'd0},
      '{6'b010110, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd1,        5'd0}
    };
    for (int i = 0; i < 18; i++) begin
`ifdef ALU_SERIAL_SHIFT_EN
      lat = int'(vecs[i].k);
`else
      lat = 0;
`endif
      id = 4'(i + 3);
      step();
      drive(vecs[i].op, vecs[i].vj, vecs[i].vk, vecs[i].imm, id);
      step();
      bus.start = 1'b0;
      for (int j = 0; j < lat; j++) begin
        @(negedge clk_in);
        total++; if (bus.out_rdy !== 1'b0 || bus.busy !== 1'b1) begin
          bad++; $display("FAIL op%0d_shifting: got rdy=%b busy=%b want rdy=0 busy=1", i, bus.out_rdy, bus.busy);
        end
        step();
      end
      @(negedge clk_in);
      total++; if (bus.out_rdy !== 1'b1) begin bad++; $display("FAIL op%0d_out_rdy: got %b want 1", i, bus.out_rdy); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL op%0d_busy: got %b want 1", i, bus.busy); end
      total++; if (bus.out_value !== vecs[i].exp) begin bad++; $display("FAIL op%0d_value: got %h want %h", i, bus.out_value, vecs[i].exp); end
      total++; if (bus.out_id !== id) begin bad++; $display("FAIL op%0d_id: got %h want %h", i, bus.out_id, id); end
      step();
      @(negedge clk_in);
      total++; if (bus.out_rdy !== 1'b0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL op%0d_drop: got rdy=%b busy=%b want 0 0", i, bus.out_rdy, bus.busy);
      end
      total++; if (bus.out_value !== vecs[i].exp) begin bad++; $display("FAIL op%0d_hold: got %h want %h", i, bus.out_value, vecs[i].exp); end
    end
  endtask

  task automatic test_clear();
    step();
    drive(6'b100011, 32'd5, 32'd7, 32'd0, 4'd5);
    step();
    bus.start = 1'b0;
    clear     = 1'b1;
    @(negedge clk_in);
    total++; if (bus.out_rdy !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL clear_after_start: got rdy=%b busy=%b want 0 0", bus.out_rdy, bus.busy);
    end
    step();
    clear = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      total++; if (bus.out_rdy !== 1'b0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL clear_after_quiet%0d: got rdy=%b busy=%b want 0 0", c, bus.out_rdy, bus.busy);
      end
      step();
    end
    drive(6'b000011, 32'd1, 32'd1, 32'd0, 4'd6);
    clear = 1'b1;
    @(negedge clk_in);
    total++; if (bus.out_rdy !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL clear_with_start: got rdy=%b busy=%b want 0 0", bus.out_rdy, bus.busy);
    end
    step();
    bus.start = 1'b0;
    clear     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      total++; if (bus.out_rdy !== 1'b0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL clear_with_quiet%0d: got rdy=%b busy=%b want 0 0", c, bus.out_rdy, bus.busy);
      end
      step();
    end
    drive(6'b000011, 32'd10, 32'd20, 32'd0, 4'd7);
    step();
    bus.start = 1'b0;
    @(negedge clk_in);
    total++; if (bus.out_rdy !== 1'b1) begin bad++; $display("FAIL clear_recover_rdy: got %b want 1", bus.out_rdy); end
    total++; if (bus.out_value !== 32'd30) begin bad++; $display("FAIL clear_recover_value: got %h want %h", bus.out_value, 32'd30); end
    total++; if (bus.out_id !== 4'd7) begin bad++; $display("FAIL clear_recover_id: got %h want 7", bus.out_id); end
    step();
    @(negedge clk_in);
    total++; if (bus.out_rdy !== 1'b0) begin bad++; $display("FAIL clear_recover_drop: got %b want 0", bus.out_rdy); end
  endtask

  task automatic test_back_to_back();
    step();
    drive(6'b000011, 32'hFFFFFFFF, 32'd2, 32'd0, 4'd9);
    step();
    bus.start = 1'b0;
    @(negedge clk_in);
    total++; if (bus.out_rdy !== 1'b1 || bus.out_value !== 32'd1 || bus.out_id !== 4'd9) begin
      bad++; $display("FAIL b2b_first: got rdy=%b value=%h id=%h want 1 00000001 9", bus.out_rdy, bus.out_value, bus.out_id);
    end
    step();
    drive(6'b011001, 32'h10, 32'd0, 32'h1, 4'd10);
    @(negedge clk_in);
    total++; if (bus.out_rdy !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL b2b_gap: got rdy=%b busy=%b want 0 0", bus.out_rdy, bus.busy);
    end
    step();
    bus.start = 1'b0;
    @(negedge clk_in);
    total++; if (bus.out_rdy !== 1'b1 || bus.out_value !== 32'h11 || bus.out_id !== 4'd10) begin
      bad++; $display("FAIL b2b_second: got rdy=%b value=%h id=%h want 1 00000011 a", bus.out_rdy, bus.out_value, bus.out_id);
    end
    step();
    @(negedge clk_in);
    total++; if (bus.out_rdy !== 1'b0) begin bad++; $display("FAIL b2b_drop: got %b want 0", bus.out_rdy); end
  endtask

  task automatic test_rdy_stall();
    step();
    drive(6'b000011, 32'd2, 32'd3, 32'd0, 4'd12);
    step();
    bus.start = 1'b0;
    rdy_in    = 1'b0;
    @(negedge clk_in);
    total++; if (bus.out_rdy !== 1'b1) begin bad++; $display("FAIL stall_rdy0: got %b want 1", bus.out_rdy); end
    step();
    @(negedge clk_in);
    total++; if (bus.out_rdy !== 1'b1 || bus.out_value !== 32'd5) begin
      bad++; $display("FAIL stall_rdy1: got rdy=%b value=%h want 1 00000005", bus.out_rdy, bus.out_value);
    end
    step();
    rdy_in = 1'b1;
    @(negedge clk_in);
    total++; if (bus.out_rdy !== 1'b1 || bus.out_id !== 4'd12) begin
      bad++; $display("FAIL stall_release: got rdy=%b id=%h want 1 c", bus.out_rdy, bus.out_id);
    end
    step();
    @(negedge clk_in);
    total++; if (bus.out_rdy !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL stall_drop: got rdy=%b busy=%b want 0 0", bus.out_rdy, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_clear();
    test_back_to_back();
    test_rdy_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Single-issue integer execute unit sitting directly downstream of the reservation station. It accepts one ready instruction per start pulse, as operands vj/vk/imm, the 6-bit op code and the destination RoB id. It computes the result and broadcasts it for one cycle on the result port. The result port feeds the RoB/CDB and the station's `ALU_finish_rdy`.

## Interface
- `RoB_BITS`, default `` `RoB_BITS `` (from const.v): width of the RoB id.
- `clk_in`  in  1  system clock; all state updates on its rising edge.
- `rst_in`  in  1  reset, synchronous, active-high.
- `rdy_in`  in  1  global ready; when low, all state is frozen.
- `clear`  in  1  RoB flush; squashes the in-flight op.
- `start`  in  1  from `waiting_ALU`; one-cycle request to begin an op.
- `vj`  in  32  operand 1.
- `vk`  in  32  operand 2.
- `imm`  in  32  immediate (for AUIPC it is pc+imm, computed upstream).
- `op`  in  6  {funct7 bit, funct3, type[1:0]}; type 0=U, 1=I, 2=B, 3=R; 6'b111111=J.
- `rob_id`  in  RoB_BITS  destination, from `RS_finish_id`.
- `busy`  out  1  op accepted and not yet broadcast.
- `out_rdy`  out  1  result valid; drives `ALU_finish_rdy`.
- `out_id`  out  RoB_BITS  RoB id of the result.
- `out_value`  out  32  result value.
- Reset values: `busy`=0, `out_rdy`=0, `out_id`=0, `out_value`=0.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE & start: latch operands, op and id.
    - Non-shift op, or shamt 0: compute, go to DONE.
    - Serial shift: go to SHIFT.
  - SHIFT: one bit position per cycle; go to DONE when the remaining count reaches 0.
  - DONE: `out_rdy`=1 for exactly one rdy cycle, then IDLE.
- Operand 2 is `vk` for R/B and `imm` for I. U and J results = `imm` (J link value is supplied upstream).
- funct3 decode, I and R:
  - 000 add; sub only for R with funct7=1.
  - 001 sll.
  - 010 slt (signed).
  - 011 sltu.
  - 100 xor.
  - 101 srl/sra, selected by funct7.
  - 110 or.
  - 111 and.
- I-type ignores funct7 except for funct3=101.
- B: `out_value`={31'b0,taken}. funct3 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; 010/011 give taken=0.
- Shift amount = operand2[4:0]. sra fills with vj[31]. All arithmetic is 32-bit wrap-around, no flags.
- start while `busy`=1: ignored. A simulation-only assertion fires.
- `clear` has priority over everything: next state IDLE, `busy`/`out_rdy` forced to 0, and a same-cycle start is dropped.
- `rst_in` has priority over `clear`.
- `rdy_in`=0: no state changes. An asserted `out_rdy` stays asserted until one rdy cycle has elapsed.

## Timing
- Start sampled at edge N.
  - Non-shift ops: `out_rdy` high during cycle N+1, low at N+2.
  - `busy` is high during N+1; it drops together with `out_rdy`.
- Serial shift with shamt k>0: `out_rdy` is high during cycle N+1+k.
- Back-to-back: a new start is accepted in the cycle after DONE, i.e. at most one op every 2 cycles.
- `out_id`/`out_value` are held stable while `out_rdy`=1, and keep their last values afterwards.

## Configuration
- `ALU_SERIAL_SHIFT_EN`
  - Defined: sll/srl/sra use the SHIFT state, one bit per cycle, via the sub-module.
  - Undefined: shifts use a combinational barrel shifter with single-cycle latency; the SHIFT state is never entered.
- The port list is identical in both builds.

## Structure
- Add to const.v:
  - ALU type codes (`ALU_TYPE_U/I/B/R`) and `ALU_OP_J` (6'b111111).
  - funct3 constants.
  - FSM state encodings.
- Sub-module `alu_serial_shifter`, present only under `ALU_SERIAL_SHIFT_EN`:
  - ports: load, value, amount, dir, arith, done, result.
  - it holds the count and shift registers.

## Test plan
- Reset held 2 cycles with start=1 -> `busy`=0, `out_rdy`=0 and all outputs 0 throughout.
- R sub: vj=5, vk=7, op funct7=1/000/R, id=3 -> exactly one cycle later `out_rdy`=1, `out_value`=0xFFFFFFFE, `out_id`=3; low the following cycle.
- B blt: vj=0xFFFFFFFF, vk=1 -> `out_value`=1. bltu with the same operands -> `out_value`=0.
- sra: vj=0x80000000, imm=4, I with funct7=1 -> 0xF8000000. Result at N+1 when undefined, at N+5 with `ALU_SERIAL_SHIFT_EN`.
- addi: imm=0xFFFFFFFF with funct7=1 -> add, not sub; vj=1 gives 0.
- clear asserted the cycle after start, and start+clear asserted together -> no `out_rdy` ever, `busy`=0. The next start completes normally.
